// File: rtl/crc32_slice4_engine.sv
// Streaming reflected CRC-32 engine: slice-by-4 on full beats,
// byte-serial tail for a partial final beat, one result per packet.
module crc32_slice4_engine #(
    parameter logic [31:0] CRC_INIT   = 32'hFFFF_FFFF,
    parameter logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic [2:0]  in_bytes,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_crc,
    output logic [9:0]  tbl_addr_1,
    output logic [9:0]  tbl_addr_2,
    output logic [9:0]  tbl_addr_3,
    output logic [9:0]  tbl_addr_4,
    input  logic [31:0] tbl_data_1,
    input  logic [31:0] tbl_data_2,
    input  logic [31:0] tbl_data_3,
    input  logic [31:0] tbl_data_4,
    output logic [9:0]  tbl_addr_5,
    input  logic [31:0] tbl_data_5
);

    typedef enum logic [1:0] {
        RUN,
        TAIL,
        OUT
    } state_t;

    state_t      state;
    logic [31:0] crc;
    logic [31:0] tail_data;
    logic [2:0]  tail_cnt;

    logic [31:0] c;
    logic [31:0] slice_next;
    logic [31:0] byte_next;
    logic        accept;
    logic        full;

    assign c = crc ^ in_data;

    // Lowest byte has the most zero bytes left to advance over, so T3.
    assign tbl_addr_1 = {2'd3, c[7:0]};
    assign tbl_addr_2 = {2'd2, c[15:8]};
    assign tbl_addr_3 = {2'd1, c[23:16]};
    assign tbl_addr_4 = {2'd0, c[31:24]};
    assign slice_next = tbl_data_1 ^ tbl_data_2 ^ tbl_data_3 ^ tbl_data_4;

    assign tbl_addr_5 = {2'b00, crc[7:0] ^ tail_data[7:0]};
    assign byte_next  = {8'h00, crc[31:8]} ^ tbl_data_5;

    assign accept = in_valid & in_ready;
    assign full   = (in_bytes == 3'd0) || (in_bytes > 3'd3);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= RUN;
            crc       <= CRC_INIT;
            out_valid <= 1'b0;
            out_crc   <= 32'h0;
            tail_cnt  <= 3'd0;
            tail_data <= 32'h0;
            in_ready  <= 1'b1;
        end else begin
            unique case (state)
                RUN: begin
                    if (accept) begin
                        if (!in_last) begin
                            crc <= slice_next;
                        end else if (full) begin
                            out_crc   <= slice_next ^ CRC_XOROUT;
                            crc       <= CRC_INIT;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            state     <= OUT;
                        end else begin
                            tail_data <= in_data;
                            tail_cnt  <= in_bytes;
                            in_ready  <= 1'b0;
                            state     <= TAIL;
                        end
                    end
                end
                TAIL: begin
                    tail_data <= {8'h00, tail_data[31:8]};
                    tail_cnt  <= tail_cnt - 3'd1;
                    if (tail_cnt == 3'd1) begin
                        out_crc   <= byte_next ^ CRC_XOROUT;
                        crc       <= CRC_INIT;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        crc <= byte_next;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule
